// File: rtl/valid_ready_credit_transmitter.sv
`default_nettype none
// ============================================================================
// valid_ready_credit_transmitter : credit-counted link transmitter, no ready wire
// Rev 1.0
// ============================================================================
module valid_ready_credit_transmitter #(
  parameter int WIDTH        = 8,
  parameter int CREDITS      = 4,
  parameter int CREDITS_LOG2 = $clog2(CREDITS)
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      credit_return_valid,
  input  logic [CREDITS_LOG2:0]     credit_return_count,
  output logic [CREDITS_LOG2:0]     credit_count,
  output logic                      idle,
  output logic                      credit_error
);

  localparam int c_CW = CREDITS_LOG2 + 1;
  localparam int c_NW = CREDITS_LOG2 + 2;
  localparam logic [c_CW-1:0] c_FULL   = c_CW'(CREDITS);
  localparam logic [c_NW-1:0] c_FULL_N = c_NW'(CREDITS);

  logic [c_CW-1:0]  r_count;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_err;

  logic             w_xfer;
  logic [c_NW-1:0]  w_ret;
  logic [c_NW-1:0]  w_sum;
  logic             w_ovf;
  logic [c_CW-1:0]  w_next;

  assign in_ready = (r_count != '0);
  assign w_xfer   = in_valid & in_ready;

  // One extra bit of headroom so an over-return is visible before saturation.
  always_comb begin
    w_ret  = credit_return_valid ? {1'b0, credit_return_count} : '0;
    w_sum  = {1'b0, r_count} - {{(c_NW-1){1'b0}}, w_xfer} + w_ret;
    w_ovf  = (w_sum > c_FULL_N);
    w_next = w_ovf ? c_FULL : w_sum[c_CW-1:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_count     <= c_FULL;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else if (flush) begin
      r_count     <= c_FULL;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_count     <= w_next;
      r_out_valid <= w_xfer;
      if (w_xfer) r_out_data <= in_data;
      if (w_ovf)  r_err      <= 1'b1;
    end
  end

  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign credit_count = r_count;
  assign credit_error = r_err;
  assign idle         = (r_count == c_FULL) & ~r_out_valid;

  a_credit_bound: assert property (@(posedge clock) disable iff (!resetn) r_count <= c_FULL);

endmodule
`default_nettype wire

// File: doc/valid_ready_credit_transmitter.md
Name: valid_ready_credit_transmitter

Overview:
Transmit end of a credit-based link whose far end is a valid-ready FIFO with a fixed number of entries. The transmitter accepts a valid-ready stream and forwards each beat as a registered single-cycle pulse with no backpressure. It spends one credit per beat and regains credits from returns issued by the receiver when it pops entries. The credit counter guarantees the far FIFO never overflows, so the link needs no ready wire.

Parameters:
WIDTH, 8, data bits per beat.
CREDITS, 4, initial credit count; equals far-end FIFO DEPTH; must be >= 1.
CREDITS_LOG2, `CLOG2(CREDITS), counter index width; counter and level fields are CREDITS_LOG2+1 bits.

Ports:
clock  input  1  single clock, rising edge.
resetn  input  1  asynchronous active-low reset.
flush  input  1  synchronous; restores the full credit count; asserted together with the receiver's flush.
in_data  input  WIDTH  upstream payload.
in_valid  input  1  upstream beat valid.
in_ready  output  1  transmitter can take a beat this cycle.
out_data  output  WIDTH  link payload, registered.
out_valid  output  1  link beat strobe, registered, one cycle per beat.
credit_return_valid  input  1  receiver returns credits this cycle.
credit_return_count  input  CREDITS_LOG2+1  number of credits returned, 1..CREDITS; ignored when credit_return_valid=0.
credit_count  output  CREDITS_LOG2+1  credits currently held.
idle  output  1  all credits home and no beat in flight on the output register.
credit_error  output  1  sticky; a return would push the count above CREDITS.

Behaviour:
- Reset (resetn=0, asynchronous): credit_count=CREDITS, out_valid=0, out_data=0, credit_error=0. As a result in_ready=1 and idle=1.
- in_ready = (credit_count != 0). Combinational from the register only, with no path from in_valid.
- Transfer when in_valid & in_ready. Next cycle: out_valid=1 and out_data=in_data. With no transfer, out_valid=0 and out_data holds its last value.
- No bypass: latency in->out is exactly 1 cycle. Back-to-back transfers give a continuous out_valid.
- Counter update: next = credit_count - transfer + (credit_return_valid ? credit_return_count : 0). Compute in CREDITS_LOG2+2 bits.
  - Simultaneous transfer and return of n: net change is n-1.
  - Return at count 0 takes effect next cycle only; in_ready stays low this cycle.
- Overflow: if the computed next value exceeds CREDITS:
  - credit_count saturates to CREDITS;
  - credit_error sets and stays set until resetn or flush.
- A return with credit_return_valid=1 and credit_return_count=0 is a no-op, not an error.
- Flush (synchronous, highest priority over transfer and return in the same cycle): credit_count=CREDITS, out_valid=0, credit_error=0.
  - in_ready stays driven from the pre-flush count. An upstream beat accepted in the flush cycle is dropped and not counted.
- idle = (credit_count == CREDITS) & ~out_valid.
- Reset mid-stream: any beat in the output register is lost and the counter reloads. The receiver must be reset in the same domain event.
- Invariant, checked by assertion: credit_count <= CREDITS at all times.
- in_data is not required to be stable while in_valid=1 and in_ready=0, because in_ready does not depend on in_valid. Upstream valid-ready rules still apply.

Test Plan:
- Reset then idle:
  - resetn low 3 cycles then high -> credit_count=4, in_ready=1, idle=1, out_valid=0, credit_error=0.
- Exhaust credits:
  - CREDITS=4, in_valid=1 for 6 cycles, data 0x10..0x15, no returns -> out_valid high 4 cycles with 0x10..0x13, one cycle after each accept.
  - credit_count 4,3,2,1,0; in_ready=0 from the 5th cycle; 0x14 held upstream.
- Return unblocks:
  - At count 0, credit_return_valid=1, count=1 -> next cycle credit_count=1, in_ready=1.
  - 0x14 accepted, appears on out_data the following cycle, credit_count=0.
- Simultaneous:
  - At count 2, transfer plus return of 3 in the same cycle -> credit_count=4, no error.
  - At count 3, transfer plus return of 1 -> credit_count=3.
- Overflow:
  - At count 3, no transfer, return of 2 -> credit_count=4, credit_error=1.
  - Error stays 1 through 10 idle cycles and clears on a flush pulse.
- Flush mid-stream:
  - At count 1 with out_valid=1, assert flush with in_valid=1 -> next cycle credit_count=4, out_valid=0, idle=1, no out_valid for the flushed beat.
